// File: rtl/sdf_stage_sequencer.sv
// Control sequencer for one radix-2 SDF FFT stage.
// Indexes accepted samples within a frame and produces the per-sample control
// word (fill/butterfly select, twiddle address, frame markers). After the last
// frame it drains the stage delay line with D bubble cycles.
//
// Handshake: a sample is accepted when in_valid & in_ready are both high on a
// rising edge. in_ready is low only while flushing, and upstream must hold any
// sample it offers during that time. Every control word, bubbles included,
// appears one cycle after the edge that produced it, qualified by ctl_valid.
module sdf_stage_sequencer #(
    parameter int N_LOG2 = 4,
    parameter int STAGE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              flush_req,
    output logic              in_ready,
    output logic              ctl_valid,
    output logic              ctl_bf_sel,
    output logic [N_LOG2-2:0] ctl_tw_addr,
    output logic              ctl_first,
    output logic              ctl_last,
    output logic              ctl_bubble,
    output logic              sync_err,
    output logic              busy
);

    localparam int BF_BIT = N_LOG2 - 1 - STAGE;
    localparam int D      = 1 << BF_BIT;

    localparam logic [N_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [N_LOG2-1:0] D_MASK    = N_LOG2'(D - 1);
    localparam logic [N_LOG2-1:0] FCNT_LAST = N_LOG2'(D - 1);
    localparam logic [N_LOG2-1:0] ONE       = N_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [N_LOG2-1:0] fcnt_q, fcnt_d;
    logic              dirty_q, dirty_d;
    logic              pend_q, pend_d;

    logic              valid_q, valid_d;
    logic              bf_q, bf_d;
    logic [N_LOG2-2:0] tw_q, tw_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              bubble_q, bubble_d;
    logic              serr_q, serr_d;

    logic              accept;
    logic              emit;
    logic [N_LOG2-1:0] idx;

    assign in_ready = (state_q != S_FLUSH);
    assign accept   = in_valid & in_ready;

    // Next state, counters and the control word for this cycle's accept or bubble.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        dirty_d  = dirty_q;
        pend_d   = pend_q;
        valid_d  = 1'b0;
        bf_d     = 1'b0;
        tw_d     = '0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        bubble_d = 1'b0;
        serr_d   = 1'b0;
        emit     = 1'b0;
        idx      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_first) begin
                    // Frame start: this sample is index 0. A flush request in
                    // the same cycle is remembered for the end of this frame.
                    idx     = '0;
                    emit    = 1'b1;
                    cnt_d   = ONE;
                    state_d = S_RUN;
                    if (flush_req) pend_d = 1'b1;
                end else if (flush_req && dirty_q) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    emit = 1'b1;
                    // A mid-frame in_first resynchronises the frame to this sample.
                    if (in_first && (cnt_q != '0)) begin
                        idx    = '0;
                        serr_d = 1'b1;
                    end
                    cnt_d = idx + ONE;
                    if (idx == CNT_LAST) begin
                        dirty_d = 1'b1;
                        if (pend_q || flush_req) begin
                            state_d = S_FLUSH;
                            fcnt_d  = '0;
                        end
                    end else if (flush_req) begin
                        pend_d = 1'b1;
                    end
                end else if (flush_req) begin
                    pend_d = 1'b1;
                end
            end
            S_FLUSH: begin
                // One bubble per cycle; the delay line is empty after D of them.
                valid_d  = 1'b1;
                bubble_d = 1'b1;
                fcnt_d   = fcnt_q + ONE;
                if (fcnt_q == FCNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    dirty_d = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            bf_d    = idx[BF_BIT];
            tw_d    = bf_d ? (N_LOG2-1)'((idx & D_MASK) << STAGE) : '0;
            first_d = (idx == '0);
            last_d  = (idx == CNT_LAST);
        end
    end

    // State, counters and registered control outputs; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            dirty_q  <= 1'b0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            bf_q     <= 1'b0;
            tw_q     <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            bubble_q <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            dirty_q  <= dirty_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            bf_q     <= bf_d;
            tw_q     <= tw_d;
            first_q  <= first_d;
            last_q   <= last_d;
            bubble_q <= bubble_d;
            serr_q   <= serr_d;
        end
    end

    assign ctl_valid   = valid_q;
    assign ctl_bf_sel  = bf_q;
    assign ctl_tw_addr = tw_q;
    assign ctl_first   = first_q;
    assign ctl_last    = last_q;
    assign ctl_bubble  = bubble_q;
    assign sync_err    = serr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdf_stage_sequencer.sv
// Bench for sdf_stage_sequencer: two N_LOG2=3 instances, STAGE=0 (D=4) and
// STAGE=1 (D=2), driven with directed frames against hand-written tables.
module tb_sdf_stage_sequencer;

    localparam int W = 7;  // {sync_err, bubble, bf_sel, tw[1:0], first, last}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid0 = 1'b0, in_first0 = 1'b0, flush0 = 1'b0;
    logic       in_valid1 = 1'b0, in_first1 = 1'b0, flush1 = 1'b0;
    logic       in_ready0, ctl_valid0, bf0, first0, last0, bubble0, serr0, busy0;
    logic       in_ready1, ctl_valid1, bf1, first1, last1, bubble1, serr1, busy1;
    logic [1:0] tw0, tw1;

    sdf_stage_sequencer #(.N_LOG2(3), .STAGE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_first(in_first0),
        .flush_req(flush0), .in_ready(in_ready0), .ctl_valid(ctl_valid0),
        .ctl_bf_sel(bf0), .ctl_tw_addr(tw0), .ctl_first(first0), .ctl_last(last0),
        .ctl_bubble(bubble0), .sync_err(serr0), .busy(busy0)
    );

    sdf_stage_sequencer #(.N_LOG2(3), .STAGE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_first(in_first1),
        .flush_req(flush1), .in_ready(in_ready1), .ctl_valid(ctl_valid1),
        .ctl_bf_sel(bf1), .ctl_tw_addr(tw1), .ctl_first(first1), .ctl_last(last1),
        .ctl_bubble(bubble1), .sync_err(serr1), .busy(busy1)
    );

    // ---------------- hand-computed tables ----------------
    int bf_tab0[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int tw_tab0[8] = '{0, 0, 0, 0, 0, 1, 2, 3};
    int bf_tab1[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int tw_tab1[8] = '{0, 0, 0, 2, 0, 0, 0, 2};
    localparam logic [W-1:0] BUBBLE_WORD = 7'b0100000;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int total = 0;
    int bad = 0;

    function automatic logic [W-1:0] word0(input int i, input bit serr);
        logic [1:0] t;
        t = 2'(tw_tab0[i]);
        return {serr, 1'b0, (bf_tab0[i] != 0), t, (i == 0), (i == 7)};
    endfunction

    function automatic logic [W-1:0] word1(input int i, input bit serr);
        logic [1:0] t;
        t = 2'(tw_tab1[i]);
        return {serr, 1'b0, (bf_tab1[i] != 0), t, (i == 0), (i == 7)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one sample to the selected instance after `gap` idle cycles.
    task automatic send(input int which, input bit first, input bit fl, input int gap);
        idle(gap);
        if (which == 0) begin
            in_valid0 = 1'b1; in_first0 = first; flush0 = fl;
        end else begin
            in_valid1 = 1'b1; in_first1 = first; flush1 = fl;
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0; in_first0 = 1'b0; flush0 = 1'b0;
        in_valid1 = 1'b0; in_first1 = 1'b0; flush1 = 1'b0;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (ctl_valid0) begin
            if (exp_q0.size() == 0)
                check("unexpected_word0", {25'd0, serr0, bubble0, bf0, tw0, first0, last0}, 32'hffff_ffff);
            else
                check("word0", {25'd0, serr0, bubble0, bf0, tw0, first0, last0}, {25'd0, exp_q0.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (ctl_valid1) begin
            if (exp_q1.size() == 0)
                check("unexpected_word1", {25'd0, serr1, bubble1, bf1, tw1, first1, last1}, 32'hffff_ffff);
            else
                check("word1", {25'd0, serr1, bubble1, bf1, tw1, first1, last1}, {25'd0, exp_q1.pop_front()});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check("reset_outputs0", {ctl_valid0, bf0, tw0, first0, last0, bubble0, serr0, busy0}, 0);
        check("reset_ready0", in_ready0, 1);
        check("reset_outputs1", {ctl_valid1, bf1, tw1, first1, last1, bubble1, serr1, busy1}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contiguous frame, STAGE=0.
        for (int i = 0; i < 8; i++) begin
            exp_q0.push_back(word0(i, 1'b0));
            send(0, i == 0, 1'b0, 0);
        end
        @(negedge clk);
        check("busy_after_frame", busy0, 1);

        // Contiguous frame, STAGE=1.
        for (int i = 0; i < 8; i++) begin
            exp_q1.push_back(word1(i, 1'b0));
            send(1, i == 0, 1'b0, 0);
        end

        // Two back-to-back frames with random gaps; only the first carries in_first.
        for (int i = 0; i < 16; i++) begin
            exp_q0.push_back(word0(i % 8, 1'b0));
            send(0, i == 0, 1'b0, $urandom_range(0, 3));
        end

        // Mid-frame in_first at index 5 resynchronises the frame.
        for (int i = 0; i < 5; i++) begin
            exp_q0.push_back(word0(i, 1'b0));
            send(0, i == 0, 1'b0, 0);
        end
        exp_q0.push_back(word0(0, 1'b1));
        send(0, 1'b1, 1'b0, 0);
        for (int i = 1; i < 8; i++) begin
            exp_q0.push_back(word0(i, 1'b0));
            send(0, 1'b0, 1'b0, 0);
        end

        // Flush requested at index 3, drained after the frame's last sample.
        for (int i = 0; i < 8; i++) begin
            exp_q0.push_back(word0(i, 1'b0));
            send(0, i == 0, i == 3, 0);
        end
        for (int k = 0; k < 4; k++) exp_q0.push_back(BUBBLE_WORD);
        in_valid0 = 1'b1;  // offered during flush, must be dropped
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) in_valid0 = 1'b0;
            check("flush_in_ready", in_ready0, (k == 5) ? 1 : 0);
            if (k >= 2) check("flush_bubble_contig", {ctl_valid0, bubble0}, 2'b11);
            if (k == 5) check("flush_busy_cleared", busy0, 0);
        end
        @(posedge clk);
        #1;
        flush0 = 1'b1;  // dirty is clear now, so this must do nothing
        idle(1);
        flush0 = 1'b0;
        idle(6);
        @(negedge clk);
        check("idle_flush_ignored_busy", busy0, 0);
        check("idle_flush_ignored_ready", in_ready0, 1);

        // Reset in the middle of a flush.
        for (int i = 0; i < 8; i++) begin
            exp_q0.push_back(word0(i, 1'b0));
            send(0, i == 0, i == 7, 0);
        end
        exp_q0.push_back(BUBBLE_WORD);
        idle(2);
        reset = 1'b1;
        #1;
        check("midflush_reset_outputs", {ctl_valid0, bf0, tw0, first0, last0, bubble0, serr0, busy0}, 0);
        check("midflush_reset_ready", in_ready0, 1);
        idle(2);
        reset = 1'b0;
        send(0, 1'b0, 1'b0, 0);  // no in_first: discarded
        idle(3);
        @(negedge clk);
        check("dropped_no_first_busy", busy0, 0);
        exp_q0.push_back(word0(0, 1'b0));
        send(0, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("restart_busy", busy0, 1);

        // Drain scoreboards with a bounded wait.
        for (int c = 0; c < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); c++)
            @(negedge clk);
        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdf_stage_sequencer.md
# sdf_stage_sequencer

Control sequencer for one radix-2 single-delay-feedback (SDF) FFT stage. It counts accepted samples within a frame and drives the stage's fill/butterfly select and twiddle address. It also generates frame markers and flushes the stage delay line with bubble cycles after the final frame. It sits beside the stage's valid-tagged delay buffer and butterfly, one instance per stage.

## Interface
- `N_LOG2`, default 4: log2 of the frame length; frame = 2^N_LOG2 samples; N_LOG2 >= 2.
- `STAGE`, default 0: stage index, 0 <= STAGE <= N_LOG2-1; delay depth D = 2^(N_LOG2-1-STAGE).
- `clk`  in  1  clock; all logic rising-edge.
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `in_valid`  in  1  sample present this cycle.
- `in_first`  in  1  sample is frame index 0; qualified by in_valid.
- `flush_req`  in  1  single-cycle pulse; requests delay-line drain after the current frame.
- `in_ready`  out  1  combinational; 1 in IDLE and RUN, 0 in FLUSH.
- `ctl_valid`  out  1  control word valid (accepted sample or bubble).
- `ctl_bf_sel`  out  1  0 = fill/pass phase, 1 = butterfly phase.
- `ctl_tw_addr`  out  N_LOG2-1  twiddle ROM address.
- `ctl_first`, `ctl_last`  out  1  frame index 0 / frame index 2^N_LOG2-1.
- `ctl_bubble`  out  1  flush cycle; no real sample.
- `sync_err`  out  1  one-cycle pulse on a mid-frame in_first.
- `busy`  out  1  state != IDLE.

## Operation
- Accept = in_valid & in_ready. While in_ready=0, samples are dropped, and upstream must hold them.
- Internal state:
  - `cnt`: N_LOG2-bit sample index of the next accepted sample.
  - `fcnt`: flush counter.
  - `dirty`: the delay line holds frame data.
  - `flush_pend`: a flush request is latched.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - Accept with in_first starts the frame: the sample gets index 0, cnt <= 1, next state RUN.
  - Accept without in_first: the sample is discarded, and ctl_valid stays 0.
  - flush_req with dirty=1 goes to FLUSH; with dirty=0 it is ignored.
- RUN:
  - Every accept emits a control word for index i = cnt, then cnt <= cnt+1, wrapping 2^N_LOG2-1 -> 0.
  - in_first on an accept with cnt != 0: sync_err pulses, the sample is re-indexed as 0, and cnt <= 1.
  - in_first with cnt == 0 is legal and has no effect.
  - Back-to-back frames need no in_first.
  - Accept of index 2^N_LOG2-1: ctl_last=1 and dirty <= 1. Then:
    - if flush_pend, or flush_req in that same cycle, next state FLUSH;
    - otherwise stay in RUN.
  - flush_req at any other time in RUN sets flush_pend; it does not interrupt the frame.
- FLUSH:
  - Emits exactly D cycles with ctl_valid=1, ctl_bubble=1, ctl_bf_sel=0, ctl_tw_addr=0, ctl_first=0, ctl_last=0.
  - Then next state IDLE, and dirty, flush_pend and cnt are cleared.
  - flush_req during FLUSH is ignored.
- Control word for index i:
  - ctl_bf_sel = bit (N_LOG2-1-STAGE) of i;
  - ctl_tw_addr = (i mod D) << STAGE when ctl_bf_sel=1, else 0 (truncated to N_LOG2-1 bits, never overflows);
  - ctl_first = (i == 0); ctl_last = (i == 2^N_LOG2-1); ctl_bubble = 0.

## Timing
- All ctl_* outputs and sync_err are registered, with 1-cycle latency. They are valid the cycle after the accept, aligned with the sample at the stage input register.
- ctl_valid=0 in any cycle after a non-accept, except FLUSH cycles.
- On reset (asynchronous, any state including mid-flush):
  - state IDLE; cnt, fcnt, dirty and flush_pend = 0;
  - all ctl_* outputs, sync_err and busy = 0; in_ready = 1.
- First accept after reset release is sampled on the first rising edge with reset low.
- Gaps in in_valid freeze cnt and the phase; no timeout.
- FLUSH entry: the first bubble appears in the cycle after ctl_last is output, and bubbles are contiguous for D cycles.
- in_ready drops in the cycle after the last-sample accept and rises in the cycle after the D-th bubble is issued.
- busy is registered with state: 1 from the cycle after the starting accept until IDLE re-entry.

## Test plan
- N_LOG2=3, STAGE=0 (D=4), 8 contiguous samples with in_first on the first:
  - ctl_bf_sel = 0,0,0,0,1,1,1,1;
  - ctl_tw_addr = 0,0,0,0,0,1,2,3;
  - ctl_first on index 0, ctl_last on index 7, all one cycle after each accept.
- N_LOG2=3, STAGE=1 (D=2), 8 samples:
  - ctl_bf_sel = 0,0,1,1,0,0,1,1;
  - ctl_tw_addr = 0,0,0,2,0,0,0,2.
- Random in_valid gaps over 2 back-to-back frames: the control sequence matches the gapless case sample-for-sample, and the second frame needs no in_first.
- in_first at index 5: sync_err pulses once, that sample has ctl_first=1, and the next ctl_last appears 7 accepts later.
- flush_req at index 3 (STAGE=0):
  - after ctl_last, exactly 4 bubble cycles with in_ready=0;
  - then IDLE with busy=0;
  - a second flush_req in IDLE is ignored (dirty=0).
- Reset asserted during the 2nd flush bubble: all outputs 0 immediately, in_ready=1; a non-in_first sample after release is dropped.
